// File: rtl/inst_issue_seq.sv
// Instruction issue sequencer: FIFO-buffers upstream instructions and holds each on core_inst
// for CORE_CYCLES cycles followed by a NOP cycle. Define INST_ISSUE_STATS_EN to add issue_count.
module inst_issue_seq #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned CORE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_W-1:0]          in_inst,
    input  logic                       hold,
    input  logic                       flush,
    output logic [INST_W-1:0]          core_inst,
    output logic                       core_busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
`ifdef INST_ISSUE_STATS_EN
    output logic [15:0]                issue_count,
`endif
    output logic                       drop_pulse
);

    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(CORE_CYCLES + 1);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e              state_q, state_d;
    logic [INST_W-1:0]   mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]     level_q, level_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [INST_W-1:0]   core_inst_q, core_inst_d;
    logic                busy_q, busy_d;
    logic                drop_q, drop_d;
    logic                push, store, pop;
`ifdef INST_ISSUE_STATS_EN
    logic [15:0]         issue_count_q, issue_count_d;
`endif

    always_comb begin
        in_ready = (level_q != LvlFull) && !flush;
        push     = in_valid && in_ready;
        // Zero-opcode words are consumed from upstream but never reach the core.
        store    = push && (in_inst[6:0] != 7'd0);
        pop      = (state_q == StIdle) && (level_q != '0) && !hold && !flush;

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        core_inst_d = core_inst_q;
        busy_d      = busy_q;
        drop_d      = push && (in_inst[6:0] == 7'd0);
`ifdef INST_ISSUE_STATS_EN
        issue_count_d = issue_count_q;
        if (pop && (issue_count_q != 16'hFFFF)) begin
            issue_count_d = issue_count_q + 16'd1;
        end
`endif

        if (flush) begin
            state_d     = StIdle;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            cnt_d       = '0;
            core_inst_d = '0;
            busy_d      = 1'b0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            level_d = level_q + LvlW'(store) - LvlW'(pop);

            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_d     = StIssue;
                        core_inst_d = mem_q[rd_ptr_q];
                        cnt_d       = CntW'(CORE_CYCLES - 1);
                        busy_d      = 1'b1;
                    end
                end
                StIssue: begin
                    if (cnt_q == '0) begin
                        state_d     = StIdle;
                        core_inst_d = '0;
                        busy_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            core_inst_q <= '0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
`ifdef INST_ISSUE_STATS_EN
            issue_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            core_inst_q <= core_inst_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
`ifdef INST_ISSUE_STATS_EN
            issue_count_q <= issue_count_d;
`endif
        end
    end

    // Storage needs no reset; level and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= in_inst;
        end
    end

    assign core_inst  = core_inst_q;
    assign core_busy  = busy_q;
    assign level      = level_q;
    assign drop_pulse = drop_q;
`ifdef INST_ISSUE_STATS_EN
    assign issue_count = issue_count_q;
`endif

endmodule

// File: tb/tb_inst_issue_seq.sv
// Directed self-checking bench for inst_issue_seq (DEPTH=4, INST_W=32, CORE_CYCLES=4).
module tb_inst_issue_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        hold;
    logic        flush;
    logic [31:0] core_inst;
    logic        core_busy;
    logic [2:0]  level;
    logic        drop_pulse;
`ifdef INST_ISSUE_STATS_EN
    logic [15:0] issue_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] Lui = 32'h123452B7;

    inst_issue_seq #(
        .DEPTH      (4),
        .INST_W     (32),
        .CORE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .hold       (hold),
        .flush      (flush),
        .core_inst  (core_inst),
        .core_busy  (core_busy),
        .level      (level),
`ifdef INST_ISSUE_STATS_EN
        .issue_count(issue_count),
`endif
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_inst = '0; hold = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (core_inst !== 32'h0) begin n_fail++; $display("FAIL reset_core_inst: got %h want 0", core_inst); end
        n_checks++;
        if (core_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", core_busy); end
        n_checks++;
        if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++;
        if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", drop_pulse); end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_inst = Lui;
        step();
        in_valid = 1'b0; in_inst = '0;
        n_checks++;
        if (level !== 3'd1) begin n_fail++; $display("FAIL single_level_after_push: got %0d want 1", level); end
        n_checks++;
        if (core_inst !== 32'h0) begin n_fail++; $display("FAIL single_latency: got %h want 0", core_inst); end
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (core_inst !== Lui || core_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_issue[%0d]: got inst %h busy %b want inst %h busy 1",
                         i, core_inst, core_busy, Lui);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (core_inst !== 32'h0 || core_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL single_gap[%0d]: got inst %h busy %b want inst 0 busy 0",
                         i, core_inst, core_busy);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [5];
        logic [31:0] exp;
        w[0] = 32'h00100093; w[1] = 32'h00200113; w[2] = 32'h00300193;
        w[3] = 32'h00400213; w[4] = 32'h00500293;
        hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_inst = w[k];
            n_checks++;
            if (in_ready !== (k < 4)) begin
                n_fail++;
                $display("FAIL b2b_in_ready[%0d]: got %b want %b", k, in_ready, (k < 4));
            end
            step();
        end
        // w[4] stays offered upstream while the FIFO is full.
        n_checks++;
        if (level !== 3'd4 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got level %0d ready %b want level 4 ready 0", level, in_ready);
        end
        n_checks++;
        if (core_inst !== 32'h0) begin n_fail++; $display("FAIL b2b_hold_idle: got %h want 0", core_inst); end
        hold = 1'b0;
        step();
        n_checks++;
        if (level !== 3'd3 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_pop: got level %0d ready %b want level 3 ready 1", level, in_ready);
        end
        for (int c = 0; c < 26; c++) begin
            exp = ((c % 5) < 4 && c < 25) ? w[c / 5] : 32'h0;
            n_checks++;
            if (core_inst !== exp) begin
                n_fail++;
                $display("FAIL b2b_seq[%0d]: got %h want %h", c, core_inst, exp);
            end
            if (c == 1) begin
                n_checks++;
                if (level !== 3'd4) begin n_fail++; $display("FAIL b2b_late_push: got %0d want 4", level); end
                in_valid = 1'b0; in_inst = '0;
            end
            step();
        end
        n_checks++;
        if (level !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d want 0", level); end
    endtask

    task automatic test_drop();
        in_valid = 1'b1; in_inst = 32'h00000000;
        step();
        n_checks++;
        if (drop_pulse !== 1'b1 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL drop_first: got drop %b level %0d want drop 1 level 0", drop_pulse, level);
        end
        in_inst = 32'h00000080;
        step();
        in_valid = 1'b0; in_inst = '0;
        n_checks++;
        if (drop_pulse !== 1'b1 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL drop_second: got drop %b level %0d want drop 1 level 0", drop_pulse, level);
        end
        step();
        n_checks++;
        if (drop_pulse !== 1'b0 || core_inst !== 32'h0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL drop_after: got drop %b inst %h level %0d want 0 0 0",
                     drop_pulse, core_inst, level);
        end
        step();
        n_checks++;
        if (core_inst !== 32'h0) begin n_fail++; $display("FAIL drop_no_issue: got %h want 0", core_inst); end
    endtask

    task automatic test_flush();
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = 32'h00A00013 + (k << 20);
            step();
        end
        in_valid = 1'b0; in_inst = '0;
        hold = 1'b0;
        step();
        n_checks++;
        if (core_inst !== 32'h00A00013 || level !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_setup: got inst %h level %0d want 00a00013 level 3", core_inst, level);
        end
        step();
        // Second ISSUE cycle: flush with a competing upstream word.
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00F00093;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0; in_inst = '0;
        n_checks++;
        if (core_inst !== 32'h0 || level !== 3'd0 || core_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got inst %h level %0d busy %b want 0 0 0",
                     core_inst, level, core_busy);
        end
        step();
        step();
        n_checks++;
        if (core_inst !== 32'h0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_no_accept: got inst %h level %0d want 0 0", core_inst, level);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_inst = 32'h00700393;
        step();
        in_valid = 1'b0; in_inst = '0;
        step();
        step();
        n_checks++;
        if (core_busy !== 1'b1) begin n_fail++; $display("FAIL arst_setup: got busy %b want 1", core_busy); end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (core_inst !== 32'h0 || core_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got inst %h busy %b want 0 0", core_inst, core_busy);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL arst_release: got ready %b level %0d want 1 0", in_ready, level);
        end
        step();
        step();
        n_checks++;
        if (core_inst !== 32'h0) begin n_fail++; $display("FAIL arst_fifo_lost: got %h want 0", core_inst); end
    endtask

`ifdef INST_ISSUE_STATS_EN
    task automatic issue_one(input logic [31:0] inst);
        in_valid = 1'b1; in_inst = inst;
        step();
        in_valid = 1'b0; in_inst = '0;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_stats();
        do_reset();
        for (int k = 0; k < 3; k++) issue_one(32'h00100093);
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) issue_one(32'h00100093);
        n_checks++;
        if (issue_count !== 16'd5) begin n_fail++; $display("FAIL stats_count: got %0d want 5", issue_count); end
        dut.issue_count_q = 16'hFFFE;
        for (int k = 0; k < 3; k++) issue_one(32'h00100093);
        n_checks++;
        if (issue_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats_saturate: got %h want ffff", issue_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_flush();
        test_async_reset();
`ifdef INST_ISSUE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
